// File: rtl/ica_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : ica_burst_responder
// Description : Memory-side responder for the display-controller instruction
//               fetch bus (ICA/DCA fetch units). A request on 'as' latches a
//               22-bit byte address, one 64-bit qword is read from the SDRAM
//               read port, and BURST_LEN 16-bit words are then streamed back
//               critical-word-first on din with burstdata_valid. The last
//               word carries the bus_ack pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BURST_LEN        words returned per transaction (2 or 4)
// Ports
//   clk              in   1   system clock, all logic on posedge
//   reset            in   1   synchronous active-high reset
//   address          in   22  byte address, valid while as=1
//   as               in   1   address strobe / transaction request
//   din              out  16  burst data word to initiator
//   burstdata_valid  out  1   din valid this cycle
//   bus_ack          out  1   transaction complete, one-cycle pulse
//   mem_req          out  1   qword read request, held until mem_ack
//   mem_addr         out  19  qword address (address[21:3])
//   mem_ack          in   1   read done, mem_rdata valid this cycle only
//   mem_rdata        in   64  qword, word k = mem_rdata[63-16k -: 16]
//   addr_err         out  1   pulse: request accepted with address[0]=1
// ============================================================================
module ica_burst_responder #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] address,
  input  logic        as,
  output logic [15:0] din,
  output logic        burstdata_valid,
  output logic        bus_ack,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        addr_err
);

  // cnt counts words already issued. The last word is issued when
  // cnt == C_LAST; cnt == C_DONE marks the bus_ack cycle, which is spent
  // outside IDLE so the still-asserted strobe cannot restart a transaction.
  localparam logic [2:0] C_LAST = 3'(BURST_LEN - 1);
  localparam logic [2:0] C_DONE = 3'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3   // aborted request waiting for the uncancellable read
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] din_q, din_d;
  logic        valid_q, valid_d;
  logic        ack_q, ack_d;
  logic        mem_req_q, mem_req_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic        aerr_q, aerr_d;
  logic [1:0]  w_q, w_d;        // next word index inside the qword
  logic [2:0]  cnt_q, cnt_d;    // words issued in this burst
  logic [63:0] qbuf_q, qbuf_d;  // captured qword

  // Big-endian word order: word 0 is the most significant halfword.
  function automatic logic [15:0] qword_word(input logic [63:0] q,
                                             input logic [1:0]  k);
    logic [15:0] r;
    case (k)
      2'd0:    r = q[63:48];
      2'd1:    r = q[47:32];
      2'd2:    r = q[31:16];
      default: r = q[15:0];
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    din_d      = '0;
    valid_d    = 1'b0;
    ack_d      = 1'b0;
    aerr_d     = 1'b0;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    qbuf_d     = qbuf_q;

    case (state_q)
      S_IDLE: begin
        if (as) begin
          mem_req_d  = 1'b1;
          mem_addr_d = address[21:3];
          w_d        = address[2:1];
          aerr_d     = address[0];
          cnt_d      = 3'd0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          qbuf_d    = mem_rdata;
          if (!as) begin
            state_d = S_IDLE;
          end else begin
            // First word is taken straight from the read bus so that it
            // appears the cycle after mem_ack; the rest come from qbuf.
            din_d   = qword_word(mem_rdata, w_q);
            valid_d = 1'b1;
            w_d     = w_q + 2'd1;
            cnt_d   = 3'd1;
            state_d = S_STREAM;
          end
        end else if (!as) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_STREAM: begin
        if (cnt_q == C_DONE || !as) begin
          state_d = S_IDLE;
        end else begin
          din_d   = qword_word(qbuf_q, w_q);
          valid_d = 1'b1;
          w_d     = w_q + 2'd1;   // 2-bit wrap keeps the burst in the qword
          cnt_d   = cnt_q + 3'd1;
          ack_d   = (cnt_q == C_LAST);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      din_q      <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      aerr_q     <= 1'b0;
      w_q        <= '0;
      cnt_q      <= '0;
      qbuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      aerr_q     <= aerr_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      qbuf_q     <= qbuf_d;
    end
  end

  assign din             = din_q;
  assign burstdata_valid = valid_q;
  assign bus_ack         = ack_q;
  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;
  assign addr_err        = aerr_q;

endmodule
`default_nettype wire

// File: tb/tb_ica_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ica_burst_responder
// Description : Directed self-checking bench for ica_burst_responder. One
//               instance uses BURST_LEN=4, a second uses BURST_LEN=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ica_burst_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // BURST_LEN=4 instance
  logic [21:0] address;
  logic        as;
  logic [15:0] din;
  logic        burstdata_valid, bus_ack, mem_req, addr_err, mem_ack;
  logic [18:0] mem_addr;
  logic [63:0] mem_rdata;

  // BURST_LEN=2 instance
  logic [21:0] address_b;
  logic        as_b;
  logic [15:0] din_b;
  logic        valid_b, ack_b, mem_req_b, addr_err_b, mem_ack_b;
  logic [18:0] mem_addr_b;
  logic [63:0] mem_rdata_b;

  ica_burst_responder #(.BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .address(address), .as(as), .din(din),
    .burstdata_valid(burstdata_valid), .bus_ack(bus_ack), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .addr_err(addr_err)
  );

  ica_burst_responder #(.BURST_LEN(2)) dut_b (
    .clk(clk), .reset(reset), .address(address_b), .as(as_b), .din(din_b),
    .burstdata_valid(valid_b), .bus_ack(ack_b), .mem_req(mem_req_b),
    .mem_addr(mem_addr_b), .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b),
    .addr_err(addr_err_b)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Logs of observed bus activity, sampled on the falling edge.
  logic [15:0] words_a[$];
  int          wcyc_a[$];
  int          ack_cyc_a[$];
  logic [15:0] ack_word_a;
  logic        ack_valid_a;
  logic [18:0] req_addr_a[$];
  int          req_cyc_a[$];
  logic        prev_req_a = 1'b0;
  int          aerr_a;
  logic [15:0] words_b[$];
  int          acks_b;
  logic [15:0] ack_word_b;

  always @(negedge clk) begin
    if (burstdata_valid) begin
      words_a.push_back(din);
      wcyc_a.push_back(cyc);
    end
    if (bus_ack) begin
      ack_cyc_a.push_back(cyc);
      ack_word_a  = din;
      ack_valid_a = burstdata_valid;
    end
    if (mem_req && !prev_req_a) begin
      req_addr_a.push_back(mem_addr);
      req_cyc_a.push_back(cyc);
    end
    prev_req_a = mem_req;
    if (addr_err) aerr_a++;
    if (valid_b) words_b.push_back(din_b);
    if (ack_b) begin
      acks_b++;
      ack_word_b = din_b;
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    words_a.delete(); wcyc_a.delete(); ack_cyc_a.delete();
    req_addr_a.delete(); req_cyc_a.delete();
    ack_word_a = '0; ack_valid_a = 1'b0; aerr_a = 0;
    prev_req_a = mem_req;
    words_b.delete(); acks_b = 0; ack_word_b = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; as = 1'b0; as_b = 1'b0;
    mem_ack = 1'b0; mem_ack_b = 1'b0;
    mem_rdata = '0; mem_rdata_b = '0;
    tick(); tick();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic start(input logic [21:0] a);
    address = a;
    as      = 1'b1;
    tick();
  endtask

  // Wait lat cycles with mem_req held, then return the qword for one cycle.
  task automatic serve(input string tag, input int lat,
                       input logic [63:0] data, output int ack_at);
    repeat (lat) tick();
    check({tag, " mem_req held"}, mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = data;
    ack_at    = cyc;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check({tag, " mem_req dropped"}, mem_req, 0);
  endtask

  task automatic wait_ack(input string tag, input bit drop);
    int seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (bus_ack) seen = 1;
    end
    check({tag, " bus_ack seen"}, seen, 1);
    if (drop) as = 1'b0;
  endtask

  task automatic check_words(input string tag, input int base,
                             input logic [63:0] exp);
    logic [15:0] g;
    for (int k = 0; k < 4; k++) begin
      g = (base + k < words_a.size()) ? words_a[base + k] : 16'hxxxx;
      check($sformatf("%s word%0d", tag, k), g, exp[63 - 16*k -: 16]);
    end
  endtask

  localparam logic [63:0] R1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RA = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] RB = 64'h0102_0304_0506_0708;
  localparam logic [63:0] RD = 64'h5A5A_A5A5_0F0F_F0F0;

  initial begin
    int at, at2;
    address = '0; address_b = '0;
    do_reset();

    // Reset state
    check("reset outs", {din, burstdata_valid, bus_ack, mem_req, mem_addr, addr_err}, 0);
    check("reset outs b", {din_b, valid_b, ack_b, mem_req_b, addr_err_b}, 0);

    // 1: aligned read
    start(22'h000400);
    check("t1 mem_req", mem_req, 1);
    check("t1 mem_addr", mem_addr, 19'h80);
    check("t1 addr_err", addr_err, 0);
    serve("t1", 3, R1, at);
    wait_ack("t1", 1'b1);
    repeat (3) tick();
    check("t1 nwords", words_a.size(), 4);
    check_words("t1", 0, R1);
    check("t1 first word cycle", (wcyc_a.size() > 0) ? wcyc_a[0] : -1, at + 1);
    check("t1 last word cycle", (wcyc_a.size() > 3) ? wcyc_a[3] : -1, at + 4);
    check("t1 nacks", ack_cyc_a.size(), 1);
    check("t1 ack cycle", (ack_cyc_a.size() > 0) ? ack_cyc_a[0] : -1, at + 4);
    check("t1 ack word", {ack_valid_a, ack_word_a}, {1'b1, 16'h4444});
    check("t1 nreqs", req_addr_a.size(), 1);

    // 2: misaligned qword, critical word first
    do_reset();
    start(22'h000404);
    check("t2 mem_addr", mem_addr, 19'h80);
    serve("t2", 2, R1, at);
    wait_ack("t2", 1'b1);
    repeat (3) tick();
    check("t2 nwords", words_a.size(), 4);
    check_words("t2", 0, 64'h3333_4444_1111_2222);
    check("t2 ack word", {ack_valid_a, ack_word_a}, {1'b1, 16'h2222});
    check("t2 nreqs", req_addr_a.size(), 1);

    // 3: back-to-back with as held high
    do_reset();
    start(22'h001000);
    serve("t3a", 1, RA, at);
    wait_ack("t3a", 1'b0);
    tick();
    check("t3 no restart in ack cycle", mem_req, 0);
    address = 22'h001008;
    tick();
    check("t3 second req", mem_req, 1);
    check("t3 second addr", mem_addr, 19'h201);
    serve("t3b", 1, RB, at2);
    wait_ack("t3b", 1'b1);
    repeat (4) tick();
    check("t3 nreqs", req_addr_a.size(), 2);
    check("t3 req0 addr", (req_addr_a.size() > 0) ? req_addr_a[0] : 19'h7FFFF, 19'h200);
    check("t3 req1 addr", (req_addr_a.size() > 1) ? req_addr_a[1] : 19'h7FFFF, 19'h201);
    check("t3 ack to req gap",
          (req_cyc_a.size() > 1 && ack_cyc_a.size() > 0) ? req_cyc_a[1] - ack_cyc_a[0] : -1, 2);
    check("t3 nwords", words_a.size(), 8);
    check_words("t3a", 0, RA);
    check_words("t3b", 4, RB);
    check("t3 nacks", ack_cyc_a.size(), 2);

    // 4: abort during fetch
    do_reset();
    start(22'h002000);
    tick();
    as = 1'b0;
    tick(); tick();
    check("t4 req held after abort", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = RD;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("t4 req released", mem_req, 0);
    repeat (4) tick();
    check("t4 no words", words_a.size(), 0);
    check("t4 no acks", ack_cyc_a.size(), 0);
    start(22'h002008);
    check("t4 next addr", mem_addr, 19'h401);
    serve("t4", 1, RD, at);
    wait_ack("t4", 1'b1);
    repeat (3) tick();
    check_words("t4", 0, RD);
    check("t4 nacks", ack_cyc_a.size(), 1);

    // 5: reset in the middle of streaming
    do_reset();
    start(22'h000400);
    serve("t5", 1, R1, at);
    tick();
    reset = 1'b1;
    tick();
    check("t5 outs after reset", {din, burstdata_valid, bus_ack, mem_req, addr_err}, 0);
    reset = 1'b0;
    as    = 1'b0;
    clear_logs();
    mem_ack = 1'b1; mem_rdata = RA;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    check("t5 late ack ignored", {words_a.size() == 0, ack_cyc_a.size() == 0, mem_req}, 3'b110);
    start(22'h000408);
    check("t5 new addr", mem_addr, 19'h81);
    serve("t5b", 1, RB, at);
    wait_ack("t5b", 1'b1);
    repeat (3) tick();
    check_words("t5b", 0, RB);

    // 6: odd address flags addr_err but otherwise behaves as the even one
    do_reset();
    start(22'h000401);
    check("t6 addr_err pulse", addr_err, 1);
    check("t6 mem_addr", mem_addr, 19'h80);
    tick();
    check("t6 addr_err single", addr_err, 0);
    serve("t6", 0, R1, at);
    wait_ack("t6", 1'b1);
    repeat (3) tick();
    check_words("t6", 0, R1);
    check("t6 aerr count", aerr_a, 1);

    // 6b: BURST_LEN=2 instance
    address_b = 22'h000401;
    as_b = 1'b1;
    tick();
    check("t6b addr_err", addr_err_b, 1);
    mem_ack_b = 1'b1; mem_rdata_b = R1;
    tick();
    mem_ack_b = 1'b0; mem_rdata_b = '0;
    begin
      int seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
        tick();
        if (ack_b) seen = 1;
      end
      check("t6b bus_ack seen", seen, 1);
    end
    as_b = 1'b0;
    repeat (4) tick();
    check("t6b nwords", words_b.size(), 2);
    check("t6b word0", (words_b.size() > 0) ? words_b[0] : 16'hxxxx, 16'h1111);
    check("t6b word1", (words_b.size() > 1) ? words_b[1] : 16'hxxxx, 16'h2222);
    check("t6b ack", {acks_b[7:0], ack_word_b}, {8'd1, 16'h2222});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
